// File: rtl/tile_map_writer.sv
// Tile map owner: packs per-tile sprite ids into a 256 x 32-bit word bank
// and serves the renderer through a registered, read-before-write port.
module tile_map_writer #(
   parameter int N_PER_ROW = 60,
   parameter int N_ROWS    = 34,
   parameter int N_WORDS   = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [5:0]  wr_col,
   input  logic [5:0]  wr_row,
   input  logic [3:0]  wr_sprite,
   input  logic        clr_start,
   input  logic [3:0]  clr_sprite,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [7:0]  current_tile,
   output logic [31:0] sprite_addr
);

   localparam logic [7:0] LAST_WORD = 8'(N_WORDS - 1);
   localparam logic [7:0] PRE_LAST  = 8'(N_WORDS - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WRITE,
      S_REJECT,
      S_CLEAR
   } state_t;

   state_t      state_reg;
   logic [5:0]  col_reg;
   logic [5:0]  row_reg;
   logic [3:0]  sprite_reg;
   logic [10:0] idx_reg;
   logic [31:0] rmw_word_reg;
   logic [7:0]  clr_cnt_reg;
   logic [3:0]  clr_sprite_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        err_reg;
   logic [31:0] sprite_addr_reg;

   logic [10:0] idx_next;
   logic        in_range;
   logic [31:0] word_merged;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [31:0] mem_wdata;

   logic [31:0] mem [N_WORDS];

   // Out-of-range coordinates may wrap here; they are rejected before use.
   assign idx_next = 11'(row_reg) * 11'(N_PER_ROW) + 11'(col_reg);
   assign in_range = (col_reg < 6'(N_PER_ROW)) && (row_reg < 6'(N_ROWS));

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_nibble
         assign word_merged[4*gi +: 4] = (idx_reg[2:0] == 3'(gi)) ? sprite_reg
                                                                  : rmw_word_reg[4*gi +: 4];
      end
   endgenerate

   // A reset cycle suppresses any write, so an aborted clear/write leaves no partial word.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = idx_reg[10:3];
      mem_wdata = word_merged;
      if (!reset) begin
         case (state_reg)
            S_WRITE: mem_we = 1'b1;
            S_CLEAR: begin
               mem_we    = 1'b1;
               mem_waddr = clr_cnt_reg;
               mem_wdata = {8{clr_sprite_reg}};
            end
            default: mem_we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sprite_addr_reg <= '0;
      end else begin
         sprite_addr_reg <= mem[current_tile];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         clr_cnt_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (clr_start) begin
                  state_reg      <= S_CLEAR;
                  clr_cnt_reg    <= '0;
                  clr_sprite_reg <= clr_sprite;
                  busy_reg       <= 1'b1;
               end else if (wr_valid) begin
                  state_reg  <= S_CALC;
                  col_reg    <= wr_col;
                  row_reg    <= wr_row;
                  sprite_reg <= wr_sprite;
                  busy_reg   <= 1'b1;
               end
            end
            S_CALC: begin
               // Fetch the target word now so WRITE can merge one nibble into it.
               idx_reg      <= idx_next;
               rmw_word_reg <= mem[idx_next[10:3]];
               done_reg     <= 1'b1;
               if (in_range) begin
                  state_reg <= S_WRITE;
               end else begin
                  state_reg <= S_REJECT;
                  err_reg   <= 1'b1;
               end
            end
            S_WRITE, S_REJECT: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
            S_CLEAR: begin
               if (clr_cnt_reg == LAST_WORD) begin
                  state_reg   <= S_IDLE;
                  busy_reg    <= 1'b0;
                  clr_cnt_reg <= '0;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 8'd1;
                  if (clr_cnt_reg == PRE_LAST) begin
                     done_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready    = (state_reg == S_IDLE) && !clr_start;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign err         = err_reg;
   assign sprite_addr = sprite_addr_reg;

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: table-driven tile writes, clear
// sequences and a reference map model checked through a read scoreboard.
module tb_tile_map_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [5:0]  wr_col = '0;
   logic [5:0]  wr_row = '0;
   logic [3:0]  wr_sprite = '0;
   logic        clr_start = 1'b0;
   logic [3:0]  clr_sprite = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  current_tile = '0;
   logic [31:0] sprite_addr;

   int checks = 0;
   int failures = 0;

   logic [31:0] model [256];
   logic [31:0] exp_q [$];

   typedef struct {
      logic [5:0] col;
      logic [5:0] row;
      logic [3:0] sp;
      logic       exp_err;
      int         exp_idx;
   } vec_t;

   vec_t vecs [10];

   tile_map_writer dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_col       (wr_col),
      .wr_row       (wr_row),
      .wr_sprite    (wr_sprite),
      .clr_start    (clr_start),
      .clr_sprite   (clr_sprite),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .current_tile (current_tile),
      .sprite_addr  (sprite_addr)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic read_word(input int addr, input string name);
      logic [31:0] e;
      next_cycle();
      current_tile = 8'(addr);
      exp_q.push_back(model[addr]);
      next_cycle();
      #1;
      e = exp_q.pop_front();
      chk(name, sprite_addr, e);
      $display("read word=%0d data=%h", addr, sprite_addr);
   endtask

   task automatic sweep(input string name);
      logic [31:0] e;
      for (int i = 0; i <= 256; i++) begin
         next_cycle();
         if (i < 256) begin
            current_tile = 8'(i);
            exp_q.push_back(model[i]);
         end
         #1;
         if (i > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_w%0d", name, i - 1), sprite_addr, e);
         end
      end
      $display("sweep %s complete", name);
   endtask

   task automatic do_clear(input logic [3:0] fill);
      int busy_cnt;
      int done_at;
      int done_cnt;
      busy_cnt = 0;
      done_at  = 0;
      done_cnt = 0;
      next_cycle();
      clr_start  = 1'b1;
      clr_sprite = fill;
      #1;
      chk("clr_ready_low", wr_ready, 0);
      for (int k = 1; k <= 256; k++) begin
         next_cycle();
         clr_start = 1'b0;
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            done_at = k;
            done_cnt++;
         end
      end
      chk("clr_busy_cycles", busy_cnt, 256);
      chk("clr_done_at", done_at, 256);
      chk("clr_done_count", done_cnt, 1);
      next_cycle();
      #1;
      chk("clr_after_busy", busy, 0);
      chk("clr_after_ready", wr_ready, 1);
      for (int i = 0; i < 256; i++) model[i] = {8{fill}};
      $display("clear fill=%h busy_cycles=%0d done_at=%0d", fill, busy_cnt, done_at);
   endtask

   task automatic do_write(input logic [5:0] col, input logic [5:0] row,
                           input logic [3:0] sp, input logic exp_err);
      next_cycle();
      wr_col    = col;
      wr_row    = row;
      wr_sprite = sp;
      wr_valid  = 1'b1;
      #1;
      chk("wr_ready_T", wr_ready, 1);
      next_cycle();
      wr_valid = 1'b0;
      #1;
      chk("wr_busy_T1", busy, 1);
      chk("wr_done_T1", done, 0);
      next_cycle();
      #1;
      chk("wr_done_T2", done, 1);
      chk("wr_err_T2", err, 32'(exp_err));
      next_cycle();
      #1;
      chk("wr_ready_T3", wr_ready, 1);
      chk("wr_busy_T3", busy, 0);
      chk("wr_done_T3", done, 0);
      $display("write col=%0d row=%0d sprite=%h err=%0b", col, row, sp, exp_err);
   endtask

   initial begin
      int w;
      int n;
      int ready_seen;
      int busy_cnt;
      int done_at;

      vecs[0] = '{col: 6'd3,  row: 6'd0,  sp: 4'hA, exp_err: 1'b0, exp_idx: 3};
      vecs[1] = '{col: 6'd59, row: 6'd33, sp: 4'hF, exp_err: 1'b0, exp_idx: 2039};
      vecs[2] = '{col: 6'd0,  row: 6'd1,  sp: 4'h7, exp_err: 1'b0, exp_idx: 60};
      vecs[3] = '{col: 6'd7,  row: 6'd2,  sp: 4'h2, exp_err: 1'b0, exp_idx: 127};
      vecs[4] = '{col: 6'd60, row: 6'd0,  sp: 4'h9, exp_err: 1'b1, exp_idx: 0};
      vecs[5] = '{col: 6'd0,  row: 6'd34, sp: 4'h9, exp_err: 1'b1, exp_idx: 0};
      vecs[6] = '{col: 6'd63, row: 6'd63, sp: 4'h9, exp_err: 1'b1, exp_idx: 0};
      vecs[7] = '{col: 6'd4,  row: 6'd0,  sp: 4'hC, exp_err: 1'b0, exp_idx: 4};
      vecs[8] = '{col: 6'd59, row: 6'd32, sp: 4'h1, exp_err: 1'b0, exp_idx: 1979};
      vecs[9] = '{col: 6'd3,  row: 6'd0,  sp: 4'h6, exp_err: 1'b0, exp_idx: 3};

      // Reset state
      repeat (3) next_cycle();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_sprite_addr", sprite_addr, 0);
      reset = 1'b0;
      next_cycle();
      chk("rst_ready", wr_ready, 1);

      // Clear with 0x5
      do_clear(4'h5);
      sweep("fill5");

      // Clear to 0, then first single write read back as a constant
      do_clear(4'h0);
      for (int v = 0; v < 10; v++) begin
         do_write(vecs[v].col, vecs[v].row, vecs[v].sp, vecs[v].exp_err);
         if (!vecs[v].exp_err) begin
            w = vecs[v].exp_idx / 8;
            n = vecs[v].exp_idx % 8;
            model[w][4*n +: 4] = vecs[v].sp;
         end
         read_word(vecs[v].exp_idx / 8, $sformatf("vec%0d_word", v));
         if (v == 0) chk("first_write_w0", sprite_addr, 32'h0000A000);
         if (v == 1) begin
            chk("last_tile_w254", sprite_addr, 32'hF0000000);
            read_word(255, "last_tile_w255");
         end
      end
      sweep("table");

      // Clear and write requested in the same cycle
      next_cycle();
      clr_start  = 1'b1;
      clr_sprite = 4'h2;
      wr_valid   = 1'b1;
      wr_col     = 6'd5;
      wr_row     = 6'd0;
      wr_sprite  = 4'hB;
      #1;
      chk("both_ready_T", wr_ready, 0);
      ready_seen = 0;
      busy_cnt   = 0;
      done_at    = 0;
      for (int k = 1; k <= 256; k++) begin
         next_cycle();
         clr_start = 1'b0;
         #1;
         if (wr_ready) ready_seen = 1;
         if (busy) busy_cnt++;
         if (done) done_at = k;
      end
      chk("both_ready_low", ready_seen, 0);
      chk("both_busy_cycles", busy_cnt, 256);
      chk("both_done_at", done_at, 256);
      for (int i = 0; i < 256; i++) model[i] = 32'h22222222;
      next_cycle();
      #1;
      chk("both_ready_T257", wr_ready, 1);
      next_cycle();
      wr_valid = 1'b0;
      #1;
      chk("both_calc_busy", busy, 1);
      next_cycle();
      #1;
      chk("both_done", done, 1);
      chk("both_err", err, 0);
      model[0][23:20] = 4'hB;
      $display("write col=5 row=0 sprite=b after clear fill=2");
      read_word(0, "both_w0");
      chk("both_w0_const", sprite_addr, 32'h22B22222);
      read_word(1, "both_w1");

      // Reset at clear counter 100
      do_clear(4'h1);
      next_cycle();
      clr_start  = 1'b1;
      clr_sprite = 4'h3;
      for (int k = 1; k <= 100; k++) begin
         next_cycle();
         clr_start = 1'b0;
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      #1;
      chk("abort_sprite_addr", sprite_addr, 0);
      chk("abort_busy_in_rst", busy, 0);
      chk("abort_done_in_rst", done, 0);
      next_cycle();
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_ready", wr_ready, 1);
      for (int i = 0; i < 100; i++) model[i] = 32'h33333333;
      $display("clear fill=3 aborted by reset at word 100");
      sweep("abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tile_map_writer.md
# tile_map_writer

Owns the tile map that the sprite renderer reads. Game logic issues per-tile writes as (column, row, sprite id), and the block packs them into 4-bit nibbles in a 256-word × 32-bit register bank. The renderer reads that bank through a registered read port (`current_tile` → `sprite_addr`). The block also supports a bulk clear that fills the whole map with one sprite id.

## Interface

Parameters:
- `N_PER_ROW`, 60: tiles per screen row.
- `N_ROWS`, 34: tile rows, including the partial bottom row.
- `N_WORDS`, 256: map words; 8 tiles per word.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. Pixel clock domain, shared with the renderer.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: tile write request valid.
- `wr_ready` out 1: block can accept a tile write.
- `wr_col` in 6: tile column, 0..59.
- `wr_row` in 6: tile row, 0..33.
- `wr_sprite` in 4: sprite id to store.
- `clr_start` in 1: one-cycle pulse that starts a bulk clear.
- `clr_sprite` in 4: fill sprite id, sampled with `clr_start`.
- `busy` out 1: high in any non-IDLE state.
- `done` out 1: one-cycle pulse on completion of an accepted write, a rejected write, or a clear.
- `err` out 1: one-cycle pulse, coincident with `done`, when a write had out-of-range coordinates.
- `current_tile` in 8: renderer word address.
- `sprite_addr` out 32: word at `current_tile`, registered.

## Operation

- Tile index: `idx = wr_row*60 + wr_col`, 11 bits, maximum 2039.
  - Word address is `idx[10:3]`.
  - Nibble is `idx[2:0]`, located at bits `[4*n +: 4]`.
- States and transitions:
  - IDLE:
    - `clr_start` high → CLEAR. `clr_start` has priority over `wr_valid` in the same cycle; the write stays pending with `wr_ready` low.
    - Otherwise `wr_valid && wr_ready` → CALC. Column, row and sprite are latched at this point.
  - CALC:
    - Registers `idx`.
    - Range check: `col >= 60` or `row >= 34` → REJECT.
    - Otherwise → WRITE.
  - WRITE:
    - Read-modify-write of one word; only the addressed nibble changes.
    - Pulses `done`, then → IDLE.
  - REJECT:
    - Memory is not touched.
    - Pulses `done` and `err`, then → IDLE.
  - CLEAR:
    - An 8-bit counter runs 0..255, writing `{8{clr_sprite_latched}}` to one word per cycle.
    - At counter 255: pulse `done`, then → IDLE.
    - `clr_start` and `wr_valid` are ignored while in CLEAR.
- `wr_ready = (state == IDLE) && !clr_start`.
- Read port:
  - Always active and independent of state: `sprite_addr <= mem[current_tile]` every cycle.
  - Read-before-write. If the same word is written in the same cycle, `sprite_addr` returns the old value; the new value is visible the next cycle.
- Reset:
  - state = IDLE, counter = 0.
  - Outputs: `busy=0`, `done=0`, `err=0`, `sprite_addr=0`. `wr_ready=1` from the first cycle after reset deasserts.
  - Memory contents are NOT reset. Software must issue a clear after power-up.
- Reset during CLEAR or WRITE aborts immediately:
  - Words already written keep their new values.
  - The in-flight WRITE is discarded if reset is asserted in that cycle.

## Timing

- Accepted write:
  - Handshake in cycle T.
  - CALC in T+1.
  - WRITE in T+2, with `done` high in T+2.
  - Memory updated at the end of T+2; `wr_ready` is high again in T+3.
  - Throughput is 1 write per 3 cycles.
- Rejected write: handshake at T, `done` and `err` at T+2, ready again at T+3.
- Clear:
  - `clr_start` at T.
  - Words 0..255 are written in T+1..T+256; `done` is high in T+256.
  - `wr_ready` is high again in T+257.
- Read latency: 1 cycle from `current_tile` to `sprite_addr`.
- `busy` is high in every cycle that `state != IDLE`.

## Test plan

- Reset, then a single write: `col=3, row=0, sprite=0xA`.
  - Required: idx=3, word 0 bits `[15:12]` = 0xA, all other nibbles unchanged.
  - Required: `done` at T+2, and `sprite_addr` = 0x0000A000 one cycle after `current_tile=0`, given the map was cleared to 0 beforehand.
- Clear with fill 0x5.
  - Required: `busy` high for exactly 256 cycles, `done` at T+256.
  - Required: every word reads 0x55555555.
- Last tile: clear with 0, then write `col=59, row=33, sprite=0xF`.
  - Required: idx=2039, word 254 = 0xF0000000, and word 255 still 0.
- Out-of-range write: `col=60, row=0`.
  - Required: `done` and `err` at T+2, and no word in memory changes.
- `clr_start` and `wr_valid` asserted in the same cycle.
  - Required: the clear runs first, with `wr_ready` low throughout.
  - Required: the write is accepted at T+257 and its nibble overwrites the fill value.
- Reset asserted at clear cycle 100 (fill 0x3 over a map previously all 0x1).
  - Required: words 0..99 read 0x33333333, words 100..255 read 0x11111111.
  - Required: `busy=0` and `wr_ready=1` after reset deasserts.
